ex_alu_muldiv: RTL

//   Parametrised execute stage: full MIPS R-type ALU (logic, add/sub, compare, shifts) plus an

---
 rtl/ex_alu_muldiv.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_alu_muldiv.sv
// Execute stage: MIPS R-type ALU with zero-latency results, plus an iterative
// multiply/divide unit that owns HI/LO and holds the pipeline while it runs.
module ex_alu_muldiv #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SHAMT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            funct,
    input  logic [DATA_W-1:0]     operand_1,
    input  logic [DATA_W-1:0]     operand_2,
    input  logic [SHAMT_W-1:0]    shamt,
    input  logic                  write_reg_en_in,
    input  logic [REG_ADDR_W-1:0] write_reg_addr_in,
    input  logic                  flush,
    output logic [DATA_W-1:0]     result_out,
    output logic                  write_reg_en_out,
    output logic [REG_ADDR_W-1:0] write_reg_addr_out,
    output logic                  overflow_out,
    output logic                  stall_req
);

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_W - 1);
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [DATA_W-1:0]  D_ZERO   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0]  D_ONES   = {DATA_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Magnitude of a value, treated as two's complement only when is_signed is set.
    function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] v, input logic is_signed);
        f_mag = (is_signed && v[DATA_W-1]) ? (D_ZERO - v) : v;
    endfunction

    state_t                r_state;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic [SHAMT_W-1:0]    r_cnt;
    // Upper half: partial product / partial remainder. Lower half: multiplier / quotient.
    logic [2*DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]     r_opb;      // multiplicand or divisor magnitude
    logic [DATA_W-1:0]     r_op1;      // raw dividend, returned in HI on divide by zero
    logic                  r_is_div;
    logic                  r_neg_main; // negate product / quotient
    logic                  r_neg_rem;  // negate remainder
    logic                  r_div0;

    logic                  w_is_mul;
    logic                  w_is_div;
    logic                  w_signed;
    logic [DATA_W-1:0]     w_add;
    logic [DATA_W-1:0]     w_sub;
    logic                  w_add_ovf;
    logic                  w_sub_ovf;
    logic [DATA_W-1:0]     w_result;
    logic                  w_ovf;
    logic                  w_wr_en;
    logic [DATA_W:0]       w_mul_sum;
    logic [DATA_W:0]       w_mul_top;
    logic [2*DATA_W-1:0]   w_mul_next;
    logic [DATA_W:0]       w_div_shift;
    logic [DATA_W:0]       w_div_diff;
    logic                  w_div_ok;
    logic [2*DATA_W-1:0]   w_div_next;
    logic [2*DATA_W-1:0]   w_prod;
    logic [DATA_W-1:0]     w_fin_hi;
    logic [DATA_W-1:0]     w_fin_lo;

    assign w_is_mul  = (funct == F_MULT) || (funct == F_MULTU);
    assign w_is_div  = (funct == F_DIV)  || (funct == F_DIVU);
    assign w_signed  = (funct == F_MULT) || (funct == F_DIV);
    assign w_add     = operand_1 + operand_2;
    assign w_sub     = operand_1 - operand_2;
    assign w_add_ovf = (operand_1[DATA_W-1] == operand_2[DATA_W-1]) && (w_add[DATA_W-1] != operand_1[DATA_W-1]);
    assign w_sub_ovf = (operand_1[DATA_W-1] != operand_2[DATA_W-1]) && (w_sub[DATA_W-1] != operand_1[DATA_W-1]);

    // Zero-latency ALU result, overflow flag and write-enable steering.
    always_comb begin
        w_result = D_ZERO;
        w_ovf    = 1'b0;
        w_wr_en  = write_reg_en_in;
        case (funct)
            F_SLL:  w_result = operand_2 << shamt;
            F_SRL:  w_result = operand_2 >> shamt;
            F_SRA:  w_result = $signed(operand_2) >>> shamt;
            F_SLLV: w_result = operand_2 << operand_1[SHAMT_W-1:0];
            F_SRLV: w_result = operand_2 >> operand_1[SHAMT_W-1:0];
            F_SRAV: w_result = $signed(operand_2) >>> operand_1[SHAMT_W-1:0];
            F_ADD: begin
                w_result = w_add;
                w_ovf    = w_add_ovf;
                if (w_add_ovf) begin
                    w_wr_en = 1'b0;
                end else begin
                    w_wr_en = write_reg_en_in;
                end
            end
            F_ADDU: w_result = w_add;
            F_SUB: begin
                w_result = w_sub;
                w_ovf    = w_sub_ovf;
                if (w_sub_ovf) begin
                    w_wr_en = 1'b0;
                end else begin
                    w_wr_en = write_reg_en_in;
                end
            end
            F_SUBU: w_result = w_sub;
            F_AND:  w_result = operand_1 & operand_2;
            F_OR:   w_result = operand_1 | operand_2;
            F_XOR:  w_result = operand_1 ^ operand_2;
            F_NOR:  w_result = ~(operand_1 | operand_2);
            F_SLT:  w_result = {{(DATA_W-1){1'b0}}, ($signed(operand_1) < $signed(operand_2))};
            F_SLTU: w_result = {{(DATA_W-1){1'b0}}, (operand_1 < operand_2)};
            F_MFHI: w_result = r_hi;
            F_MFLO: w_result = r_lo;
            F_MTHI: w_wr_en  = 1'b0;
            F_MTLO: w_wr_en  = 1'b0;
            default: w_result = D_ZERO;
        endcase
        if (flush) begin
            w_wr_en = 1'b0;
        end else begin
            w_wr_en = w_wr_en;
        end
    end

    // One radix-2 step of shift-add multiply and of restoring division.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_opb};
        w_mul_top   = r_acc[0] ? w_mul_sum : {1'b0, r_acc[2*DATA_W-1:DATA_W]};
        w_mul_next  = {w_mul_top, r_acc[DATA_W-1:1]};
        w_div_shift = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_div_ok    = ~w_div_diff[DATA_W];
        w_div_next  = {(w_div_ok ? w_div_diff[DATA_W-1:0] : w_div_shift[DATA_W-1:0]),
                       r_acc[DATA_W-2:0], w_div_ok};
    end

    // Sign fix-ups and special cases applied to the finished magnitude result.
    always_comb begin
        w_prod   = r_neg_main ? ({(2*DATA_W){1'b0}} - r_acc) : r_acc;
        w_fin_hi = w_prod[2*DATA_W-1:DATA_W];
        w_fin_lo = w_prod[DATA_W-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_fin_hi = r_op1;
                w_fin_lo = D_ONES;
            end else begin
                w_fin_hi = r_neg_rem  ? (D_ZERO - r_acc[2*DATA_W-1:DATA_W]) : r_acc[2*DATA_W-1:DATA_W];
                w_fin_lo = r_neg_main ? (D_ZERO - r_acc[DATA_W-1:0]) : r_acc[DATA_W-1:0];
            end
        end else begin
            w_fin_hi = w_prod[2*DATA_W-1:DATA_W];
            w_fin_lo = w_prod[DATA_W-1:0];
        end
    end

    // Mul/div sequencer; also the only writer of HI/LO (MTHI/MTLO and results).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hi       <= D_ZERO;
            r_lo       <= D_ZERO;
            r_cnt      <= CNT_ZERO;
            r_acc      <= {(2*DATA_W){1'b0}};
            r_opb      <= D_ZERO;
            r_op1      <= D_ZERO;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div0     <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mul) begin
                        r_state    <= S_MUL;
                        r_cnt      <= CNT_LAST;
                        r_acc      <= {D_ZERO, f_mag(operand_2, w_signed)};
                        r_opb      <= f_mag(operand_1, w_signed);
                        r_is_div   <= 1'b0;
                        r_neg_main <= w_signed && (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
                        r_neg_rem  <= 1'b0;
                        r_div0     <= 1'b0;
                    end else if (w_is_div) begin
                        r_state    <= S_DIV;
                        r_cnt      <= CNT_LAST;
                        r_acc      <= {D_ZERO, f_mag(operand_1, w_signed)};
                        r_opb      <= f_mag(operand_2, w_signed);
                        r_op1      <= operand_1;
                        r_is_div   <= 1'b1;
                        r_neg_main <= w_signed && (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
                        r_neg_rem  <= w_signed && operand_1[DATA_W-1];
                        r_div0     <= (operand_2 == D_ZERO);
                    end else if (funct == F_MTHI) begin
                        r_hi <= operand_1;
                    end else if (funct == F_MTLO) begin
                        r_lo <= operand_1;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ZERO) begin
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ZERO) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_hi    <= w_fin_hi;
                    r_lo    <= w_fin_lo;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result_out         = rst ? D_ZERO : w_result;
    assign write_reg_en_out   = rst ? 1'b0 : w_wr_en;
    assign write_reg_addr_out = rst ? {REG_ADDR_W{1'b0}} : write_reg_addr_in;
    assign overflow_out       = rst ? 1'b0 : w_ovf;
    assign stall_req          = ~rst & ~flush &
                                (((r_state == S_IDLE) & (w_is_mul | w_is_div)) |
                                 (r_state == S_MUL) | (r_state == S_DIV));

endmodule
